// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pkg
// Description : Shared types for the JTAG data registers and AXI master engine.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

    typedef enum logic [2:0] {
        TXN_IDLE    = 3'd0,
        TXN_BUSY    = 3'd1,
        TXN_OK      = 3'd2,
        TXN_SLVERR  = 3'd3,
        TXN_DECERR  = 3'd4,
        TXN_TIMEOUT = 3'd5
    } axi_txn_status_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } jtag_axi_fsm_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Sized for the widest supported bus; narrower instances use the low bits.
    localparam int c_req_addr_w = 64;
    localparam int c_req_data_w = 64;

    typedef struct packed {
        logic                        write;
        logic [c_req_addr_w-1:0]     addr;
        logic [c_req_data_w-1:0]     wdata;
        logic [c_req_data_w/8-1:0]   wstrb;
    } jtag_axi_req_t;

    typedef struct packed {
        logic                        busy;
        axi_txn_status_t             status;
        logic                        timeout;
        logic                        dropped;
        logic [c_req_data_w-1:0]     rdata;
    } jtag_axi_status_t;

    function automatic axi_txn_status_t resp_to_status(input logic [1:0] resp);
        axi_txn_status_t s;
        case (resp)
            RESP_OKAY, RESP_EXOKAY: s = TXN_OK;
            RESP_SLVERR:            s = TXN_SLVERR;
            default:                s = TXN_DECERR;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_axi_master_if.sv
`default_nettype none
// ============================================================================
// Module      : jtag_axi_master_if
// Description : AXI4-Lite bus bundle between the JTAG master engine and fabric.
// Revision    : 1.0 - initial release
// ============================================================================
interface jtag_axi_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/jtag_axi_timeout.sv
`default_nettype none
// ============================================================================
// Module      : jtag_axi_timeout
// Description : Saturating handshake watchdog; TIMEOUT_CYC of 0 never expires.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_axi_timeout #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_expired
);
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_limit)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT_CYC != 0) && (r_cnt == c_limit);
endmodule
`default_nettype wire

// File: rtl/jtag_axi_master.sv
`default_nettype none
// ============================================================================
// Module      : jtag_axi_master
// Description : Single-beat AXI4-Lite master driven by JTAG Update-DR requests.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_axi_master
    import jtag_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  wire logic                tck,
    input  wire logic                trstn,
    input  wire logic                req_valid_i,
    input  wire logic                req_write_i,
    input  wire logic [ADDR_W-1:0]   req_addr_i,
    input  wire logic [DATA_W-1:0]   req_wdata_i,
    input  wire logic [DATA_W/8-1:0] req_wstrb_i,
    input  wire logic                clr_status_i,
    output logic                     busy_o,
    output axi_txn_status_t          status_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     timeout_o,
    output logic                     dropped_o,
    jtag_axi_master_if.master        m
);
    jtag_axi_fsm_t       r_state, w_state_nxt;
    logic                r_busy, r_launch, r_aw_done, r_w_done;
    axi_txn_status_t     r_status;
    logic [DATA_W-1:0]   r_rdata, r_wdata;
    logic [ADDR_W-1:0]   r_awaddr, r_araddr;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic                r_timeout, r_dropped;
    logic                w_accept, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic                w_done, w_expired;

    assign w_accept = (r_state == ST_IDLE) && req_valid_i;
    assign w_aw_hs  = r_awvalid && m.awready;
    assign w_w_hs   = r_wvalid  && m.wready;
    assign w_b_hs   = r_bready  && m.bvalid;
    assign w_ar_hs  = r_arvalid && m.arready;
    assign w_r_hs   = r_rready  && m.rvalid;
    assign w_done   = w_b_hs || w_r_hs;

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (req_valid_i) w_state_nxt = req_write_i ? ST_WR : ST_RD;
            ST_WR:   if (w_b_hs)      w_state_nxt = ST_IDLE;
            ST_RD:   if (w_r_hs)      w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    jtag_axi_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk       (tck),
        .rst_n     (trstn),
        .i_clr     (w_accept || w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs),
        .i_en      (r_busy),
        .o_expired (w_expired)
    );

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            r_busy    <= 1'b0;
            r_launch  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_status  <= TXN_IDLE;
            r_rdata   <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_araddr  <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_busy    <= 1'b1;
                        r_status  <= TXN_BUSY;
                        r_launch  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (req_write_i) begin
                            r_awaddr <= req_addr_i;
                            r_wdata  <= req_wdata_i;
                            r_wstrb  <= req_wstrb_i;
                        end else begin
                            r_araddr <= req_addr_i;
                        end
                    end
                end
                ST_WR: begin
                    if (r_launch) begin
                        r_launch  <= 1'b0;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                    end
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    // An early bvalid must not be taken before both AW and W have landed.
                    r_bready <= (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs) && !w_b_hs;
                    if (w_b_hs) begin
                        r_busy   <= 1'b0;
                        r_status <= resp_to_status(m.bresp);
                    end
                end
                ST_RD: begin
                    if (r_launch) begin
                        r_launch  <= 1'b0;
                        r_arvalid <= 1'b1;
                    end
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                    if (w_r_hs) begin
                        r_rready <= 1'b0;
                        r_busy   <= 1'b0;
                        r_status <= resp_to_status(m.rresp);
                        if (!m.rresp[1]) r_rdata <= m.rdata;
                    end
                end
                default: ;
            endcase
            // The bus stays live on timeout; only the reported status changes.
            if (w_expired && r_busy && !w_done) r_status <= TXN_TIMEOUT;
        end
    end

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            r_timeout <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            if (w_expired && r_busy) r_timeout <= 1'b1;
            else if (clr_status_i)   r_timeout <= 1'b0;
            if (req_valid_i && r_busy) r_dropped <= 1'b1;
            else if (clr_status_i)     r_dropped <= 1'b0;
        end
    end

    assign busy_o    = r_busy;
    assign status_o  = r_status;
    assign rdata_o   = r_rdata;
    assign timeout_o = r_timeout;
    assign dropped_o = r_dropped;

    assign m.awaddr  = r_awaddr;
    assign m.awprot  = 3'b000;
    assign m.awvalid = r_awvalid;
    assign m.wdata   = r_wdata;
    assign m.wstrb   = r_wstrb;
    assign m.wvalid  = r_wvalid;
    assign m.bready  = r_bready;
    assign m.araddr  = r_araddr;
    assign m.arprot  = 3'b000;
    assign m.arvalid = r_arvalid;
    assign m.rready  = r_rready;
endmodule
`default_nettype wire

// File: tb/tb_jtag_axi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_axi_master
// Description : Directed self-checking bench for the JTAG AXI4-Lite master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_axi_master;
    import jtag_pkg::*;

    logic            tck;
    logic            trstn;
    logic            req_valid, req_write, clr_status;
    logic [31:0]     req_addr, req_wdata;
    logic [3:0]      req_wstrb;
    logic            busy, timeout, dropped;
    axi_txn_status_t status;
    logic [31:0]     rdata;
    int              total;
    int              bad;

    jtag_axi_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    jtag_axi_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .tck          (tck),
        .trstn        (trstn),
        .req_valid_i  (req_valid),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wstrb_i  (req_wstrb),
        .clr_status_i (clr_status),
        .busy_o       (busy),
        .status_o     (status),
        .rdata_o      (rdata),
        .timeout_o    (timeout),
        .dropped_o    (dropped),
        .m            (axi)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
        tick();
        req_valid = 1'b0; axi.arready = 1'b1;
        tick();
        tick();
        axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = data; axi.rresp = resp;
        tick();
        axi.rvalid = 1'b0; axi.rresp = 2'b00;
    endtask

    initial begin
        total = 0; bad = 0;
        trstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; clr_status = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
        tick(); tick();
        chk("rst_busy",    busy, 0);
        chk("rst_status",  status, TXN_IDLE);
        chk("rst_rdata",   rdata, 0);
        chk("rst_valids",  {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
        chk("rst_flags",   {timeout, dropped}, 0);
        chk("rst_awaddr",  axi.awaddr, 0);
        trstn = 1'b1;
        tick();

        // Write with immediately ready slave
        axi.awready = 1'b1; axi.wready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1000_0040;
        req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF;
        tick();
        req_valid = 1'b0;
        chk("wr1_busy_c1",   busy, 1);
        chk("wr1_status_bz", status, TXN_BUSY);
        chk("wr1_awv_c1",    axi.awvalid, 0);
        tick();
        chk("wr1_valids",    {axi.awvalid, axi.wvalid}, 2'b11);
        chk("wr1_awaddr",    axi.awaddr, 32'h1000_0040);
        chk("wr1_wdata",     axi.wdata, 32'hDEAD_BEEF);
        chk("wr1_wstrb",     axi.wstrb, 4'hF);
        chk("wr1_prot",      {axi.awprot, axi.arprot}, 0);
        chk("wr1_busy_c2",   busy, 1);
        tick();
        chk("wr1_valids_lo", {axi.awvalid, axi.wvalid}, 2'b00);
        chk("wr1_bready",    axi.bready, 1);
        chk("wr1_busy_c3",   busy, 1);
        axi.bvalid = 1'b1; axi.bresp = RESP_OKAY;
        tick();
        axi.bvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        chk("wr1_busy_c4",   busy, 0);
        chk("wr1_status",    status, TXN_OK);
        chk("wr1_bready_lo", axi.bready, 0);

        // Read with 5-cycle arready delay
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h2000_0000;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rd1_arvalid",   axi.arvalid, 1);
        chk("rd1_araddr",    axi.araddr, 32'h2000_0000);
        repeat (4) tick();
        chk("rd1_arv_wait",  axi.arvalid, 1);
        chk("rd1_rrdy_wait", axi.rready, 0);
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        chk("rd1_arv_lo",    axi.arvalid, 0);
        chk("rd1_rready",    axi.rready, 1);
        axi.rvalid = 1'b1; axi.rdata = 32'hCAFE_F00D; axi.rresp = RESP_OKAY;
        tick();
        axi.rvalid = 1'b0;
        chk("rd1_rdata",     rdata, 32'hCAFE_F00D);
        chk("rd1_status",    status, TXN_OK);
        chk("rd1_busy",      busy, 0);

        // Write: W accepted long before AW, early bvalid held off, SLVERR
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1000_0080;
        req_wdata = 32'h0BAD_F00D; req_wstrb = 4'h3;
        tick();
        req_valid = 1'b0; axi.wready = 1'b1;
        tick();
        axi.bvalid = 1'b1; axi.bresp = RESP_SLVERR;
        tick();
        axi.wready = 1'b0;
        chk("wr2_wv_first",  {axi.awvalid, axi.wvalid}, 2'b10);
        repeat (3) tick();
        chk("wr2_bready_msk", axi.bready, 0);
        chk("wr2_busy_wait", busy, 1);
        chk("wr2_stat_wait", status, TXN_BUSY);
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        chk("wr2_awv_lo",    axi.awvalid, 0);
        chk("wr2_bready",    axi.bready, 1);
        tick();
        axi.bvalid = 1'b0; axi.bresp = RESP_OKAY;
        chk("wr2_status",    status, TXN_SLVERR);
        chk("wr2_busy",      busy, 0);
        chk("wr2_rdata_hold", rdata, 32'hCAFE_F00D);

        // OK read then DECERR read: data must be retained
        do_read(32'h3000_0000, 32'h1234_5678, RESP_OKAY);
        chk("rd2_rdata",     rdata, 32'h1234_5678);
        chk("rd2_status",    status, TXN_OK);
        do_read(32'h3000_0004, 32'hBADB_AD00, RESP_DECERR);
        chk("rd3_status",    status, TXN_DECERR);
        chk("rd3_rdata_hold", rdata, 32'h1234_5678);
        do_read(32'h3000_0008, 32'h0000_0077, RESP_EXOKAY);
        chk("rd4_exok_stat", status, TXN_OK);
        chk("rd4_exok_data", rdata, 32'h0000_0077);

        // Timeout with a stalled arready, then late completion
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4000_0000;
        tick();
        req_valid = 1'b0;
        repeat (12) tick();
        chk("to_not_yet",    timeout, 0);
        repeat (8) tick();
        chk("to_flag",       timeout, 1);
        chk("to_status",     status, TXN_TIMEOUT);
        chk("to_arvalid",    axi.arvalid, 1);
        chk("to_busy",       busy, 1);
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rdata = 32'h0000_0055; axi.rresp = RESP_OKAY;
        tick();
        axi.rvalid = 1'b0;
        chk("to_done_stat",  status, TXN_OK);
        chk("to_sticky",     timeout, 1);
        chk("to_done_data",  rdata, 32'h0000_0055);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("to_cleared",    timeout, 0);
        chk("clr_keeps_stat", status, TXN_OK);

        // Request while busy is dropped; no second AR
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h5000_0000;
        tick();
        req_addr = 32'h6000_0000;
        tick();
        req_valid = 1'b0;
        chk("drop_flag",     dropped, 1);
        chk("drop_araddr",   axi.araddr, 32'h5000_0000);
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rdata = 32'h0000_0066; axi.rresp = RESP_OKAY;
        tick();
        axi.rvalid = 1'b0;
        chk("drop_done",     busy, 0);
        repeat (3) tick();
        chk("drop_no_ar2",   {axi.arvalid, busy}, 2'b00);
        chk("drop_sticky",   dropped, 1);

        // Asynchronous reset in the middle of a write
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h7000_0000;
        tick();
        req_valid = 1'b0;
        tick();
        chk("arst_pre",      {axi.awvalid, axi.wvalid, busy}, 3'b111);
        #2 trstn = 1'b0;
        #1;
        chk("arst_valids",   {axi.awvalid, axi.wvalid, axi.bready}, 3'b000);
        chk("arst_busy",     busy, 0);
        chk("arst_status",   status, TXN_IDLE);
        chk("arst_flags",    {timeout, dropped}, 2'b00);
        chk("arst_rdata",    rdata, 0);
        tick();
        trstn = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
